// File: rtl/wb_line_ram_pkg.sv
// rtl/wb_line_ram_pkg.sv - shared line geometry and FSM encoding for wb_line_ram
//
// Purpose : line geometry constants and state encoding shared by the line RAM
//           and the cache controller, so both sides agree on line size and
//           address offset width.
// Contents: default line width and lane size, derived lane count and offset
//           width, helper functions for parameterised instances, and the FSM
//           state enum.
package wb_line_ram_pkg;

  localparam int LINE_WIDTH_DEF = 128;
  localparam int ADDR_GRAN_DEF  = 8;
  localparam int LINE_BYTES     = LINE_WIDTH_DEF / ADDR_GRAN_DEF;
  localparam int OFFSET_W       = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // Number of select lanes in one line.
  function automatic int line_lanes(input int lw, input int ag);
    return lw / ag;
  endfunction

  // Address bits that select a lane within a line; ignored for line indexing.
  function automatic int offset_width(input int lw, input int ag);
    return $clog2(lw / ag);
  endfunction

endpackage

// File: rtl/wb_line_ram_if.sv
// rtl/wb_line_ram_if.sv - Wishbone classic line-bus bundle for wb_line_ram
//
// Purpose : groups the Wishbone request/response signals of one line bus.
// Signals : wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i driven
//           by the master; wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o driven by
//           the slave.
// Modports: master (bus initiator), slave (wb_line_ram).
interface wb_line_ram_if #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_WIDTH       = 128,
  parameter int ADDR_GRANULARITY = 8
);
  import wb_line_ram_pkg::*;

  localparam int SEL_W = line_lanes(LINE_WIDTH, ADDR_GRANULARITY);

  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [LINE_WIDTH-1:0] wb_dat_i;
  logic                  wb_we_i;
  logic [SEL_W-1:0]      wb_sel_i;
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic [LINE_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

endinterface

// File: rtl/wb_line_ram_line_ram_bytewise.sv
// rtl/wb_line_ram_line_ram_bytewise.sv - single-port line RAM with per-lane write enable
//
// Purpose : synchronous single-port RAM, one line per word, lane-masked
//           writes and a registered read port; written to infer block RAM.
// Ports   : i_clk   clock
//           i_rst_n asynchronous active-low reset, clears the read register only
//           i_en    access enable (one access per enabled edge)
//           i_we    1 = write, 0 = read
//           i_sel   lane write enables
//           i_addr  line index
//           i_wdata write data
//           o_rdata registered read data, held between reads
module line_ram_bytewise #(
  parameter int WIDTH  = 128,
  parameter int LANE_W = 8,
  parameter int AW     = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_we,
  input  logic [WIDTH/LANE_W-1:0] i_sel,
  input  logic [AW-1:0]           i_addr,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata
);
  import wb_line_ram_pkg::*;

  localparam int LP_LANES = line_lanes(WIDTH, LANE_W);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] r_rdata;

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int l = 0; l < LP_LANES; l++) begin
        if (i_sel[l]) begin
          r_mem[i_addr][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read register only loads on reads, so the last read line stays visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_line_ram.sv
// rtl/wb_line_ram.sv - Wishbone classic line-wide RAM slave with programmable wait states
//
// Purpose : backing store for the cache controller: full-line reads and
//           lane-selected line writes with WAIT_STATES extra cycles of latency.
// Ports   : clk  clock
//           rst  asynchronous active-low reset
//           wb   wb_line_ram_if.slave (adr/dat_i/we/sel/stb/cyc in,
//                dat_o/ack/err/rty out)
// Option  : WB_LINE_RAM_RANGE_CHECK_EN - out-of-window addresses end with
//           wb_err_o instead of wrapping onto stored lines.
module wb_line_ram #(
  parameter int                    LINE_WIDTH       = 128,
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    ADDR_GRANULARITY = 8,
  parameter int                    DEPTH            = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                    WAIT_STATES      = 1
) (
  input logic          clk,
  input logic          rst,
  wb_line_ram_if.slave wb
);
  import wb_line_ram_pkg::*;

  localparam int LP_LANES = line_lanes(LINE_WIDTH, ADDR_GRANULARITY);
  localparam int LP_OFF_W = offset_width(LINE_WIDTH, ADDR_GRANULARITY);
  localparam logic [3:0] LP_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_sample;
  logic       w_commit;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [LP_LANES-1:0]   r_sel;
  logic [LINE_WIDTH-1:0] r_dat;

  logic                  w_cmd_we;
  logic [ADDR_WIDTH-1:0] w_cmd_adr;
  logic [LP_LANES-1:0]   w_cmd_sel;
  logic [LINE_WIDTH-1:0] w_cmd_dat;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [DEPTH-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_ram_en;
  logic [LINE_WIDTH-1:0] w_ram_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          w_sample = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // A master that drops cyc abandons the access before it commits.
        if (!wb.wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_sel <= '0;
      r_dat <= '0;
    end else if (w_sample) begin
      r_we  <= wb.wb_we_i;
      r_adr <= wb.wb_adr_i;
      r_sel <= wb.wb_sel_i;
      r_dat <= wb.wb_dat_i;
    end
  end

  // With no wait states the sample edge is also the commit edge, so the
  // live bus fields feed the RAM directly instead of the latched copy.
  assign w_cmd_we  = (r_state == ST_IDLE) ? wb.wb_we_i  : r_we;
  assign w_cmd_adr = (r_state == ST_IDLE) ? wb.wb_adr_i : r_adr;
  assign w_cmd_sel = (r_state == ST_IDLE) ? wb.wb_sel_i : r_sel;
  assign w_cmd_dat = (r_state == ST_IDLE) ? wb.wb_dat_i : r_dat;

  assign w_off = w_cmd_adr - BASE_ADDR;
  assign w_idx = DEPTH'(w_off >> LP_OFF_W);

`ifdef WB_LINE_RAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] LP_LIMIT =
    {1'b0, BASE_ADDR} + ((ADDR_WIDTH+1)'(LP_LANES) << DEPTH);

  logic r_is_err;

  assign w_oor = (w_cmd_adr < BASE_ADDR) || ({1'b0, w_cmd_adr} >= LP_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_err <= 1'b0;
    end else if (w_commit) begin
      r_is_err <= w_oor;
    end
  end

  assign wb.wb_ack_o = (r_state == ST_RESP) && !r_is_err;
  assign wb.wb_err_o = (r_state == ST_RESP) &&  r_is_err;
`else
  assign w_oor       = 1'b0;
  assign wb.wb_ack_o = (r_state == ST_RESP);
  assign wb.wb_err_o = 1'b0;
`endif

  // The RAM array is not reset, so a commit coinciding with reset is blocked
  // here rather than relying on the FSM alone.
  assign w_ram_en = w_commit && !w_oor && rst;

  line_ram_bytewise #(
    .WIDTH  (LINE_WIDTH),
    .LANE_W (ADDR_GRANULARITY),
    .AW     (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_ram_en),
    .i_we    (w_cmd_we),
    .i_sel   (w_cmd_sel),
    .i_addr  (w_idx),
    .i_wdata (w_cmd_dat),
    .o_rdata (w_ram_q)
  );

  assign wb.wb_dat_o = w_ram_q;
  assign wb.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_line_ram.sv
// tb/tb_wb_line_ram.sv - scoreboard bench for wb_line_ram at 0, 1 and 3 wait states
module tb_wb_line_ram;
  import wb_line_ram_pkg::*;

  localparam int LW    = 128;
  localparam int AW    = 32;
  localparam int G     = 8;
  localparam int DEPTH = 4;
  localparam int NL    = LW / G;
  localparam int ND    = 3;

  typedef struct {
    bit            is_err;
    bit            chk;
    logic [LW-1:0] dat;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[ND][$];
  int   resp_cnt[ND];
  int   exp_cnt[ND];
  bit   prev_resp[ND];

  logic          m_cyc[ND];
  logic          m_stb[ND];
  logic          m_we[ND];
  logic [AW-1:0] m_adr[ND];
  logic [LW-1:0] m_dat[ND];
  logic [NL-1:0] m_sel[ND];
  logic          s_ack[ND];
  logic          s_err[ND];
  logic          s_rty[ND];
  logic [LW-1:0] s_dat[ND];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [LW-1:0] pat(input int idx);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(idx);
    return {w, w, w, w};
  endfunction

  for (genvar i = 0; i < ND; i++) begin : g_dut
    wb_line_ram_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ADDR_GRANULARITY(G)) bus ();
    assign bus.wb_adr_i = m_adr[i];
    assign bus.wb_dat_i = m_dat[i];
    assign bus.wb_we_i  = m_we[i];
    assign bus.wb_sel_i = m_sel[i];
    assign bus.wb_stb_i = m_stb[i];
    assign bus.wb_cyc_i = m_cyc[i];
    assign s_ack[i]     = bus.wb_ack_o;
    assign s_err[i]     = bus.wb_err_o;
    assign s_rty[i]     = bus.wb_rty_o;
    assign s_dat[i]     = bus.wb_dat_o;

    wb_line_ram #(
      .LINE_WIDTH       (LW),
      .ADDR_WIDTH       (AW),
      .ADDR_GRANULARITY (G),
      .DEPTH            (DEPTH),
      .BASE_ADDR        (32'h0),
      .WAIT_STATES      ((i == 0) ? 0 : (i == 1) ? 1 : 3)
    ) dut (
      .clk (clk),
      .rst (rst_n),
      .wb  (bus)
    );
  end

  // Monitor: every termination pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < ND; k++) begin
      if (s_ack[k] || s_err[k]) begin
        resp_cnt[k] = resp_cnt[k] + 1;
        checks++;
        if (prev_resp[k]) begin
          errors++;
          $display("FAIL pulse_width dut%0d termination high two cycles, required one", k);
        end
        if (exp_q[k].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp dut%0d ack=%0b err=%0b required none", k, s_ack[k], s_err[k]);
        end else begin
          e = exp_q[k].pop_front();
          checks++;
          if ({s_ack[k], s_err[k]} != (e.is_err ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL resp_kind dut%0d ack=%0b err=%0b required err=%0b", k, s_ack[k], s_err[k], e.is_err);
          end
          checks++;
          if (cyc_n != e.cyc) begin
            errors++;
            $display("FAIL latency dut%0d cycle=%0d required %0d", k, cyc_n, e.cyc);
          end
          if (e.chk) begin
            checks++;
            if (s_dat[k] !== e.dat) begin
              errors++;
              $display("FAIL read_data dut%0d got %h required %h", k, s_dat[k], e.dat);
            end
          end
        end
      end
      prev_resp[k] = s_ack[k] || s_err[k];
    end
  end

  task automatic access(input int k, input bit we, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input logic [NL-1:0] s,
                        input bit xerr, input bit chk, input logic [LW-1:0] xd);
    exp_t e;
    bit   got;
    @(negedge clk);
    m_adr[k] = a; m_dat[k] = d; m_sel[k] = s; m_we[k] = we;
    m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
    @(posedge clk); #1;
    e.is_err = xerr; e.chk = chk; e.dat = xd; e.cyc = cyc_n + ws_of(k);
    exp_q[k].push_back(e);
    exp_cnt[k] = exp_cnt[k] + 1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (s_ack[k] || s_err[k]) got = 1'b1;
    end
    m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d adr=%h no termination in 40 cycles, required one", k, a);
    end
  endtask

  task automatic pre(input int k, input int idx);
    access(k, 1'b1, 32'(idx * NL), pat(idx), '1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int k = 0; k < ND; k++) begin
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0;
      resp_cnt[k] = 0; exp_cnt[k] = 0; prev_resp[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++; if (s_ack[k] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d got %b required 0", k, s_ack[k]); end
      checks++; if (s_err[k] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %b required 0", k, s_err[k]); end
      checks++; if (s_rty[k] !== 1'b0) begin errors++; $display("FAIL reset_rty dut%0d got %b required 0", k, s_rty[k]); end
      checks++; if (s_dat[k] !== '0)   begin errors++; $display("FAIL reset_dat dut%0d got %h required 0", k, s_dat[k]); end
    end
    rst_n = 1'b1;

    // Preload
    pre(1, 0); pre(1, 1); pre(1, 4);
    for (int i = 0; i < 4; i++) pre(0, i);
    pre(2, 2);

    // WS=1 read of line 4
    access(1, 1'b0, 32'h0000_0040, '0, '0, 1'b0, 1'b1, pat(4));

    // Lane-selected write, then readback
    access(1, 1'b1, 32'h0000_0010, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h00F0, 1'b0, 1'b0, '0);
    access(1, 1'b0, 32'h0000_0010, '0, '0, 1'b0, 1'b1, 128'hC0DE0001_C0DE0001_8899AABB_C0DE0001);

    // Write with no lanes selected changes nothing
    access(1, 1'b1, 32'h0000_0040, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b0, '0);
    access(1, 1'b0, 32'h0000_0040, '0, '0, 1'b0, 1'b1, pat(4));

    // WS=0 back-to-back reads
    for (int i = 0; i < 4; i++) access(0, 1'b0, 32'(i * NL), '0, '0, 1'b0, 1'b1, pat(i));

    // WS=3 write abandoned during WAIT
    @(negedge clk);
    m_adr[2] = 32'h0000_0020; m_dat[2] = ~pat(2); m_sel[2] = '1; m_we[2] = 1'b1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (resp_cnt[2] != exp_cnt[2]) begin
      errors++; $display("FAIL abort_no_ack dut2 responses=%0d required %0d", resp_cnt[2], exp_cnt[2]);
    end
    access(2, 1'b0, 32'h0000_0020, '0, '0, 1'b0, 1'b1, pat(2));

    // Reset during WAIT
    @(negedge clk);
    m_adr[2] = 32'h0000_0020; m_dat[2] = ~pat(2); m_sel[2] = '1; m_we[2] = 1'b1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (s_ack[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_ack got %b required 0", s_ack[2]); end
    checks++; if (s_err[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_err got %b required 0", s_err[2]); end
    checks++; if (s_dat[2] !== '0)   begin errors++; $display("FAIL rst_wait_dat got %h required 0", s_dat[2]); end
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(2, 1'b0, 32'h0000_0020, '0, '0, 1'b0, 1'b1, pat(2));
    access(1, 1'b0, 32'h0000_0010, '0, '0, 1'b0, 1'b1, 128'hC0DE0001_C0DE0001_8899AABB_C0DE0001);

    // One past the stored window
`ifdef WB_LINE_RAM_RANGE_CHECK_EN
    access(1, 1'b0, 32'h0000_0100, '0, '0, 1'b1, 1'b1, 128'hC0DE0001_C0DE0001_8899AABB_C0DE0001);
`else
    access(1, 1'b0, 32'h0000_0100, '0, '0, 1'b0, 1'b1, pat(0));
`endif

    repeat (4) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (resp_cnt[k] != exp_cnt[k]) begin
        errors++; $display("FAIL resp_count dut%0d got %0d required %0d", k, resp_cnt[k], exp_cnt[k]);
      end
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++; $display("FAIL pending dut%0d outstanding=%0d required 0", k, exp_q[k].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
